// File: rtl/nts_dispatch_pkg.sv
// nts dispatch arbiter shared definitions
// FSM encodings and counter/timer widths
package nts_dispatch_pkg;

  localparam int ST_W  = 3;
  localparam int TMR_W = 10;
  localparam int CNT_W = 32;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_GRANT   = 3'd1;
  localparam logic [ST_W-1:0] ST_RELEASE = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT    = 3'd3;
  localparam logic [ST_W-1:0] ST_DROP    = 3'd4;

endpackage

// File: rtl/nts_rr_select.sv
// round-robin picker: first set req at or after last+1
// ports: req (per-engine request), last (index), gnt (one-hot)
module nts_rr_select #(
  parameter int ENGINES = 4,
  parameter int IW = (ENGINES > 1) ? $clog2(ENGINES) : 1
) (
  input  logic [ENGINES-1:0] req,
  input  logic [IW-1:0]      last,
  output logic [ENGINES-1:0] gnt
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= ENGINES; k++) begin
      idx = IW'((int'(last) + k) % ENGINES);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nts_dispatch_arbiter.sv
// shares one dispatch FIFO among ENGINES nts engines
// ports: upstream FIFO view in, per-engine views out, grant, counters
module nts_dispatch_arbiter
  import nts_dispatch_pkg::*;
#(
  parameter int ENGINES = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic               i_clk,
  input  logic               i_areset_n,
  input  logic               i_dispatch_packet_available,
  input  logic               i_dispatch_fifo_empty,
  input  logic [7:0]         i_dispatch_data_valid,
  input  logic [63:0]        i_dispatch_fifo_rd_data,
  output logic               o_dispatch_fifo_rd_en,
  output logic               o_dispatch_packet_read_discard,
  input  logic [ENGINES-1:0] i_engine_busy,
  input  logic [ENGINES-1:0] i_engine_fifo_rd_en,
  output logic [ENGINES-1:0] o_engine_packet_available,
  output logic [ENGINES-1:0] o_engine_fifo_empty,
  output logic [7:0]         o_engine_data_valid,
  output logic [63:0]        o_engine_fifo_rd_data,
  output logic [ENGINES-1:0] o_grant,
  output logic [31:0]        o_dispatched_count,
  output logic [31:0]        o_dropped_count
);

  localparam int IW = (ENGINES > 1) ? $clog2(ENGINES) : 1;

  logic [ST_W-1:0]    state;
  logic [ENGINES-1:0] grant;
  logic [ENGINES-1:0] rr_gnt;
  logic [ENGINES-1:0] gnt_act;
  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      rr_idx;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_nxt;
  logic               rd_seen;
  logic               in_grant;
  logic               rd_fire;
  logic               can_grant;
  logic [CNT_W-1:0]   disp_cnt;
  logic [CNT_W-1:0]   drop_cnt;

  nts_rr_select #(
    .ENGINES(ENGINES),
    .IW     (IW)
  ) u_rr (
    .req (~i_engine_busy),
    .last(last_grant),
    .gnt (rr_gnt)
  );

  always_comb begin
    rr_idx = '0;
    for (int i = 0; i < ENGINES; i++)
      if (rr_gnt[i]) rr_idx = IW'(i);
  end

  assign in_grant  = (state == ST_GRANT);
  assign gnt_act   = in_grant ? grant : '0;
  assign rd_fire   = in_grant & |(i_engine_fifo_rd_en & grant);
  assign timer_nxt = timer + 1'b1;
  assign can_grant = i_dispatch_packet_available
                   & ~i_dispatch_fifo_empty
                   & |(~i_engine_busy);

  assign o_dispatch_fifo_rd_en = rd_fire;
  assign o_dispatch_packet_read_discard =
    (state == ST_RELEASE) | (state == ST_DROP);

  assign o_engine_packet_available =
    gnt_act & {ENGINES{i_dispatch_packet_available}};
  assign o_engine_fifo_empty =
    ~gnt_act | {ENGINES{i_dispatch_fifo_empty}};

  assign o_engine_data_valid   = i_dispatch_data_valid;
  assign o_engine_fifo_rd_data = i_dispatch_fifo_rd_data;

  assign o_grant            = grant;
  assign o_dispatched_count = disp_cnt;
  assign o_dropped_count    = drop_cnt;

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IW'(ENGINES - 1);
      timer      <= '0;
      rd_seen    <= 1'b0;
      disp_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (can_grant) begin
            grant      <= rr_gnt;
            last_grant <= rr_idx;
            timer      <= '0;
            rd_seen    <= 1'b0;
            state      <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (rd_fire) begin
            rd_seen <= 1'b1;
          end else if (!rd_seen) begin
            // timer holds cycles spent waiting for the first read
            timer <= timer_nxt;
            if (timer_nxt == TMR_W'(TIMEOUT)) begin
              state    <= ST_DROP;
              drop_cnt <= drop_cnt + 1'b1;
            end
          end else if (i_dispatch_fifo_empty) begin
            state    <= ST_RELEASE;
            disp_cnt <= disp_cnt + 1'b1;
          end
        end
        ST_RELEASE, ST_DROP: begin
          grant <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!i_dispatch_packet_available) state <= ST_IDLE;
        end
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nts_dispatch_arbiter.sv
// directed bench for nts_dispatch_arbiter
// ENGINES=4, default TIMEOUT
module tb_nts_dispatch_arbiter;

  localparam int ENGINES = 4;
  localparam int TIMEOUT = 1023;

  logic               i_clk = 1'b0;
  logic               i_areset_n;
  logic               pkt_av;
  logic               f_empty;
  logic [7:0]         d_valid;
  logic [63:0]        rd_data;
  logic               rd_en;
  logic               discard;
  logic [ENGINES-1:0] busy;
  logic [ENGINES-1:0] eng_rd;
  logic [ENGINES-1:0] eng_av;
  logic [ENGINES-1:0] eng_empty;
  logic [7:0]         eng_dv;
  logic [63:0]        eng_data;
  logic [ENGINES-1:0] grant;
  logic [31:0]        disp_cnt;
  logic [31:0]        drop_cnt;

  int nvec = 0;
  int nerr = 0;
  int rd_cnt = 0;
  int disc_cnt = 0;

  nts_dispatch_arbiter #(
    .ENGINES(ENGINES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk                         (i_clk),
    .i_areset_n                    (i_areset_n),
    .i_dispatch_packet_available   (pkt_av),
    .i_dispatch_fifo_empty         (f_empty),
    .i_dispatch_data_valid         (d_valid),
    .i_dispatch_fifo_rd_data       (rd_data),
    .o_dispatch_fifo_rd_en         (rd_en),
    .o_dispatch_packet_read_discard(discard),
    .i_engine_busy                 (busy),
    .i_engine_fifo_rd_en           (eng_rd),
    .o_engine_packet_available     (eng_av),
    .o_engine_fifo_empty           (eng_empty),
    .o_engine_data_valid           (eng_dv),
    .o_engine_fifo_rd_data         (eng_data),
    .o_grant                       (grant),
    .o_dispatched_count            (disp_cnt),
    .o_dropped_count               (drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (rd_en) rd_cnt++;
    if (discard) disc_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clr_mon;
    rd_cnt   = 0;
    disc_cnt = 0;
  endtask

  task automatic finish_pkt(input int eng, input int n);
    logic [ENGINES-1:0] one;
    one = 4'b0001;
    for (int w = 0; w < n; w++) begin
      eng_rd  = one << eng;
      rd_data = 64'hA5A5_0000_0000_0000 | 64'(w);
      d_valid = (w == n - 1) ? 8'h0F : 8'hFF;
      #1;
      chk("rd_en", rd_en, 1'b1);
      chk("bcast_data", eng_data, rd_data);
      chk("bcast_dv", eng_dv, d_valid);
      tick;
    end
    eng_rd  = '0;
    f_empty = 1'b1;
    tick;
    chk("release_discard", discard, 1'b1);
    pkt_av = 1'b0;
    tick;
    chk("wait_discard", discard, 1'b0);
    chk("wait_grant", grant, 4'b0000);
    tick;
  endtask

  task automatic run_pkt(input int eng, input int n,
                         input logic [ENGINES-1:0] exp_g);
    pkt_av  = 1'b1;
    f_empty = 1'b0;
    tick;
    chk("grant", grant, exp_g);
    finish_pkt(eng, n);
  endtask

  initial begin
    int n;
    i_areset_n = 1'b0;
    pkt_av     = 1'b1;
    f_empty    = 1'b0;
    d_valid    = 8'hFF;
    rd_data    = '0;
    busy       = '0;
    eng_rd     = 4'b1111;
    repeat (3) tick;
    chk("rst_grant", grant, 4'b0000);
    chk("rst_rd_en", rd_en, 1'b0);
    chk("rst_discard", discard, 1'b0);
    chk("rst_eng_av", eng_av, 4'b0000);
    chk("rst_eng_empty", eng_empty, 4'b1111);
    chk("rst_disp", disp_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    pkt_av     = 1'b0;
    f_empty    = 1'b1;
    eng_rd     = '0;
    i_areset_n = 1'b1;
    tick;

    // 3-word packet to engine 0, stray read from engine 2 ignored
    clr_mon();
    pkt_av  = 1'b1;
    f_empty = 1'b0;
    tick;
    chk("s1_grant", grant, 4'b0001);
    chk("s1_eng_av", eng_av, 4'b0001);
    chk("s1_eng_empty", eng_empty, 4'b1110);
    eng_rd = 4'b0100;
    #1;
    chk("s1_stray_rd", rd_en, 1'b0);
    tick;
    finish_pkt(0, 3);
    chk("s1_rd_pulses", rd_cnt, 3);
    chk("s1_discards", disc_cnt, 1);
    chk("s1_disp", disp_cnt, 1);

    // back-to-back round robin
    run_pkt(1, 2, 4'b0010);
    run_pkt(2, 1, 4'b0100);
    run_pkt(3, 2, 4'b1000);
    chk("s2_disp", disp_cnt, 4);

    // engine 1 busy after grant to 0
    run_pkt(0, 1, 4'b0001);
    busy = 4'b0010;
    run_pkt(2, 1, 4'b0100);
    busy = '0;

    // timeout drop, grant goes to engine 3
    clr_mon();
    pkt_av  = 1'b1;
    f_empty = 1'b0;
    tick;
    chk("s4_grant", grant, 4'b1000);
    n = 0;
    while (!discard && n < 2000) begin
      tick;
      n++;
    end
    chk("s4_drop_cycle", n, TIMEOUT);
    pkt_av = 1'b0;
    tick;
    tick;
    chk("s4_discards", disc_cnt, 1);
    chk("s4_rd_pulses", rd_cnt, 0);
    chk("s4_dropped", drop_cnt, 1);
    chk("s4_disp", disp_cnt, 6);

    // all engines busy
    clr_mon();
    busy    = 4'b1111;
    pkt_av  = 1'b1;
    f_empty = 1'b0;
    repeat (50) tick;
    chk("s5_rd_pulses", rd_cnt, 0);
    chk("s5_discards", disc_cnt, 0);
    chk("s5_grant_none", grant, 4'b0000);
    busy = 4'b0111;
    tick;
    chk("s5_grant", grant, 4'b1000);
    finish_pkt(3, 2);
    busy = '0;

    // reset during second read
    run_pkt(0, 1, 4'b0001);
    clr_mon();
    pkt_av  = 1'b1;
    f_empty = 1'b0;
    tick;
    chk("s6_grant", grant, 4'b0010);
    eng_rd = 4'b0010;
    tick;
    #2;
    i_areset_n = 1'b0;
    #1;
    chk("s6_grant_rst", grant, 4'b0000);
    chk("s6_rd_en_rst", rd_en, 1'b0);
    chk("s6_discard_rst", discard, 1'b0);
    chk("s6_av_rst", eng_av, 4'b0000);
    chk("s6_empty_rst", eng_empty, 4'b1111);
    chk("s6_disp_rst", disp_cnt, 0);
    chk("s6_drop_rst", drop_cnt, 0);
    eng_rd  = '0;
    pkt_av  = 1'b0;
    f_empty = 1'b1;
    tick;
    i_areset_n = 1'b1;
    tick;
    chk("s6_discards", disc_cnt, 0);
    chk("s6_rd_pulses", rd_cnt, 1);
    run_pkt(0, 2, 4'b0001);
    chk("s6_disp", disp_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
